// File: rtl/aes_encrypt_core_if.sv
// Request/response bundle shared by the AES encrypt and decrypt cores so either
// core can sit behind the same bus wrapper.
interface aes_encrypt_core_if;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_PLAIN;
  logic         AES_BUSY;
  logic         AES_DONE;
  logic [127:0] AES_MSG_ENC;

  modport master (
    output AES_START, AES_KEY, AES_MSG_PLAIN,
    input  AES_BUSY, AES_DONE, AES_MSG_ENC
  );

  modport slave (
    input  AES_START, AES_KEY, AES_MSG_PLAIN,
    output AES_BUSY, AES_DONE, AES_MSG_ENC
  );
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption: one full round per clock, round keys derived on
// the fly from the previous one, ciphertext held in the state register.
module aes_encrypt_core (
  input  logic              CLK,
  input  logic              RESET,
  aes_encrypt_core_if.slave aes_if
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Next round key from the current one: w0 absorbs SubWord(RotWord(w3)) and Rcon.
  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
    w0 = rk[127:96] ^ t ^ {rc, 24'h0};
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes and ShiftRows fused: output byte (r,c) takes input byte (r,c+r).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] rk_next, sr_state;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rk_d     = rk_q;
    rnd_d    = rnd_q;
    rk_next  = key_expand(rk_q, rcon(rnd_q));
    sr_state = sub_shift(state_q);
    case (fsm_q)
      S_WAIT: begin
        if (aes_if.AES_START) fsm_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = aes_if.AES_MSG_PLAIN ^ aes_if.AES_KEY;
        rk_d    = aes_if.AES_KEY;
        rnd_d   = 4'd1;
        fsm_d   = S_ROUND;
      end
      S_ROUND: begin
        state_d = ((rnd_q == 4'd10) ? sr_state : mix_columns(sr_state)) ^ rk_next;
        rk_d    = rk_next;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'd10) fsm_d = S_DONE;
      end
      S_DONE: begin
        if (!aes_if.AES_START) fsm_d = S_WAIT;
      end
      default: fsm_d = S_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  // NOTE: the datapath registers are reset too, because AES_MSG_ENC must read zero after RESET.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fsm_q   <= S_WAIT;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  assign aes_if.AES_BUSY    = (fsm_q == S_LOAD) || (fsm_q == S_ROUND);
  assign aes_if.AES_DONE    = (fsm_q == S_DONE);
  assign aes_if.AES_MSG_ENC = state_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed and randomized bench for aes_encrypt_core against a byte-matrix AES
// model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_encrypt_core;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  aes_encrypt_core_if bus ();

  aes_encrypt_core dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .aes_if (bus)
  );

  always #5 CLK = ~CLK;

  logic [7:0] sbox_t     [256];
  logic [7:0] inv_sbox_t [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [43:0][31:0] key_schedule(input logic [127:0] key);
    logic [43:0][31:0] w;
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return w;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [43:0][31:0] w;
    logic [7:0] st [4][4];
    logic [7:0] tmp [4][4];
    logic [127:0] out;
    w = key_schedule(key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int k = 1; k <= 10; k++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = sbox_t[st[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (k < 10)
            st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c])
                     ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
          else
            st[r][c] = tmp[r][c];
          st[r][c] = st[r][c] ^ w[4*k+c][31-8*r -: 8];
        end
    end
    out = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127-8*(4*c+r) -: 8] = st[r][c];
    return out;
  endfunction

  // Straightforward inverse cipher, used to recover plaintext from DUT ciphertext.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [43:0][31:0] w;
    logic [7:0] st [4][4];
    logic [7:0] tmp [4][4];
    logic [127:0] out;
    w = key_schedule(key);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[40+c][31-8*r -: 8];
    for (int k = 9; k >= 0; k--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][(c+r)%4] = inv_sbox_t[st[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = tmp[r][c] ^ w[4*k+c][31-8*r -: 8];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (k > 0)
            st[r][c] = gmul(8'h0e, tmp[r][c]) ^ gmul(8'h0b, tmp[(r+1)%4][c])
                     ^ gmul(8'h0d, tmp[(r+2)%4][c]) ^ gmul(8'h09, tmp[(r+3)%4][c]);
          else
            st[r][c] = tmp[r][c];
        end
    end
    out = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127-8*(4*c+r) -: 8] = st[r][c];
    return out;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Raise START with the given operands and follow the transaction until DONE.
  // lat counts edges after the WAIT->LOAD edge; -1 means DONE never arrived.
  task automatic run_enc(input logic [127:0] key, input logic [127:0] pt,
                         input int drop_at, input bit zero_inputs,
                         output logic [127:0] ct, output int lat, output int busy_n);
    bus.AES_START     = 1'b1;
    bus.AES_KEY       = key;
    bus.AES_MSG_PLAIN = pt;
    lat    = -1;
    busy_n = 0;
    for (int n = 0; n <= 20; n++) begin
      tick();
      if (n == 1 && zero_inputs) begin
        bus.AES_KEY       = '0;
        bus.AES_MSG_PLAIN = '0;
      end
      if (n == drop_at) bus.AES_START = 1'b0;
      if (bus.AES_BUSY && bus.AES_DONE) check("busy_and_done", 128'd1, 128'd0);
      if (bus.AES_BUSY) busy_n++;
      if (bus.AES_DONE) begin
        lat = n;
        break;
      end
    end
    ct = bus.AES_MSG_ENC;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] ct, key, pt;
    int lat, busy_n;
    logic [7:0] inv, s;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]     = s;
      inv_sbox_t[s] = 8'(x);
    end

    // Reset state
    RESET = 1'b1;
    bus.AES_START = 1'b0;
    bus.AES_KEY = '0;
    bus.AES_MSG_PLAIN = '0;
    tick();
    tick();
    check("rst_busy", {127'd0, bus.AES_BUSY}, 128'd0);
    check("rst_done", {127'd0, bus.AES_DONE}, 128'd0);
    check("rst_enc", bus.AES_MSG_ENC, 128'd0);
    RESET = 1'b0;
    tick();
    tick();
    check("idle_busy", {127'd0, bus.AES_BUSY}, 128'd0);

    // FIPS-197 App. B with START held
    run_enc(KEY_B, PT_B, -1, 1'b0, ct, lat, busy_n);
    check("b_latency", 128'(lat), 128'd11);
    check("b_busy_cycles", 128'(busy_n), 128'd11);
    check("b_ct", ct, CT_B);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_hold_done", {127'd0, bus.AES_DONE}, 128'd1);
      check("b_hold_busy", {127'd0, bus.AES_BUSY}, 128'd0);
      check("b_hold_ct", bus.AES_MSG_ENC, CT_B);
    end

    // START low for one cycle, then App. C.1 back-to-back
    bus.AES_START = 1'b0;
    tick();
    check("b_wait_done", {127'd0, bus.AES_DONE}, 128'd0);
    check("b_wait_ct", bus.AES_MSG_ENC, CT_B);
    run_enc(KEY_C, PT_C, -1, 1'b0, ct, lat, busy_n);
    check("c_latency", 128'(lat), 128'd11);
    check("c_ct", ct, CT_C);
    bus.AES_START = 1'b0;
    tick();
    tick();
    check("c_wait_done", {127'd0, bus.AES_DONE}, 128'd0);
    check("c_wait_busy", {127'd0, bus.AES_BUSY}, 128'd0);
    check("c_wait_ct", bus.AES_MSG_ENC, CT_C);

    // Inputs zeroed after LOAD, START dropped during round 4
    run_enc(KEY_B, PT_B, 4, 1'b1, ct, lat, busy_n);
    check("robust_latency", 128'(lat), 128'd11);
    check("robust_ct", ct, CT_B);
    tick();
    check("robust_done_1cyc", {127'd0, bus.AES_DONE}, 128'd0);
    check("robust_busy", {127'd0, bus.AES_BUSY}, 128'd0);

    // Reset during round 6 with START still high, then restart with App. C.1
    bus.AES_START = 1'b1;
    bus.AES_KEY = KEY_B;
    bus.AES_MSG_PLAIN = PT_B;
    for (int n = 0; n <= 6; n++) tick();
    check("mid_busy", {127'd0, bus.AES_BUSY}, 128'd1);
    RESET = 1'b1;
    tick();
    check("mid_rst_busy", {127'd0, bus.AES_BUSY}, 128'd0);
    check("mid_rst_done", {127'd0, bus.AES_DONE}, 128'd0);
    check("mid_rst_enc", bus.AES_MSG_ENC, 128'd0);
    RESET = 1'b0;
    run_enc(KEY_C, PT_C, -1, 1'b0, ct, lat, busy_n);
    check("restart_latency", 128'(lat), 128'd11);
    check("restart_ct", ct, CT_C);
    bus.AES_START = 1'b0;
    tick();

    // Random key/plaintext pairs against the model and the inverse cipher
    for (int i = 0; i < 100; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      run_enc(key, pt, -1, 1'b0, ct, lat, busy_n);
      check("rand_latency", 128'(lat), 128'd11);
      check("rand_ct", ct, ref_encrypt(key, pt));
      check("rand_loopback", ref_decrypt(key, ct), pt);
      bus.AES_START = 1'b0;
      tick();
      check("rand_wait_done", {127'd0, bus.AES_DONE}, 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
